// File: rtl/spi_reg_bank_pkg.sv
// Shared constants, frame field helpers and FSM state type for the SPI register bank.
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = 5;

    localparam logic [CNT_W-1:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = 5'(FRAME_BITS + 1);

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    function automatic logic [6:0] frame_addr(input logic [FRAME_BITS-1:0] frame);
        return frame[14:8];
    endfunction

    function automatic logic [7:0] frame_data(input logic [FRAME_BITS-1:0] frame);
        return frame[7:0];
    endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pins plus the control-register outputs consumed by the PWM peripheral.
interface spi_reg_bank_if;

    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;
    logic       frame_err;

    modport master (
        output sclk, copi, ncs,
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
        input  pwm_duty_cycle, wr_strobe, frame_err
    );

    modport slave (
        input  sclk, copi, ncs,
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
        output pwm_duty_cycle, wr_strobe, frame_err
    );

endinterface

// File: rtl/spi_reg_bank_sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous pin, followed by a delay flop for edge detection.
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_d;
    logic                   dly_q;

    // Next values of the synchroniser chain and the edge-detect delay flop.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    // Reset loads the pin's idle level so no spurious edge appears after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign q    = sync_q[SYNC_STAGES-1];
    assign rise = q & ~dly_q;
    assign fall = ~q & dly_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Write-only SPI mode-0 slave: shifts 16-bit frames and commits them into five control registers.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = ADDR_DUTY
) (
    input  logic           clk,
    input  logic           rst,
    spi_reg_bank_if.slave  bus
);

    localparam int ARM_W = $clog2(SYNC_STAGES + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;
    logic ncs_s, ncs_rise, ncs_fall;
    logic unused_edges;

    state_e                  state_d, state_q;
    logic [CNT_W-1:0]        cnt_d, cnt_q;
    logic [FRAME_BITS-1:0]   shreg_d, shreg_q;
    logic [7:0]              regs_d [0:4];
    logic [7:0]              regs_q [0:4];
    logic                    wr_strobe_d, wr_strobe_q;
    logic                    frame_err_d, frame_err_q;
    logic [ARM_W-1:0]        arm_cnt_d, arm_cnt_q;
    logic                    armed_d, armed_q;
    logic [6:0]              addr_s;
    logic [7:0]              data_s;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(bus.sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .d(bus.copi), .q(copi_s), .rise(copi_rise), .fall(copi_fall)
    );
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .d(bus.ncs), .q(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
    );

    assign unused_edges = ^{sclk_s, sclk_fall, copi_rise, copi_fall};
    assign addr_s       = frame_addr(shreg_q);
    assign data_s       = frame_data(shreg_q);

    // Arm only after ncs has been seen high on a post-reset sample, so a chip
    // select still low across reset cannot start a frame mid-stream.
    always_comb begin
        arm_cnt_d = arm_cnt_q;
        if (!ncs_s) begin
            arm_cnt_d = '0;
        end else if (arm_cnt_q != ARM_W'(SYNC_STAGES)) begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end else begin
            arm_cnt_d = arm_cnt_q;
        end
        armed_d = armed_q | (ncs_s & (arm_cnt_q == ARM_W'(SYNC_STAGES)));
    end

    // Frame FSM, shift register, bit counter and register-bank write decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncs_fall && armed_q) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    // The commit lands with the transition so data is visible during COMMIT.
                    state_d = COMMIT;
                    if (cnt_q != CNT_FULL) begin
                        frame_err_d = 1'b1;
                    end else if (shreg_q[FRAME_BITS-1] && (addr_s <= MAX_ADDR)) begin
                        wr_strobe_d = 1'b1;
                        case (addr_s)
                            ADDR_EN_OUT_LO: regs_d[0] = data_s;
                            ADDR_EN_OUT_HI: regs_d[1] = data_s;
                            ADDR_EN_PWM_LO: regs_d[2] = data_s;
                            ADDR_EN_PWM_HI: regs_d[3] = data_s;
                            ADDR_DUTY:      regs_d[4] = data_s;
                            default:        regs_d    = regs_q;
                        endcase
                    end else begin
                        wr_strobe_d = 1'b0;
                    end
                end else if (sclk_rise) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], copi_s};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 5'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            COMMIT: begin
                if (ncs_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            regs_q      <= '{default: 8'h00};
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            arm_cnt_q   <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
            arm_cnt_q   <= arm_cnt_d;
            armed_q     <= armed_d;
        end
    end

    assign bus.en_reg_out_7_0  = regs_q[0];
    assign bus.en_reg_out_15_8 = regs_q[1];
    assign bus.en_reg_pwm_7_0  = regs_q[2];
    assign bus.en_reg_pwm_15_8 = regs_q[3];
    assign bus.pwm_duty_cycle  = regs_q[4];
    assign bus.wr_strobe       = wr_strobe_q;
    assign bus.frame_err       = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: scoreboard of expected commit results, checked at exact latency.
module tb_spi_reg_bank;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    typedef struct packed {
        logic        wr;
        logic        err;
        logic [39:0] regs;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] m_regs [0:4];

    spi_reg_bank_if bus_if();

    spi_reg_bank #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] obs_regs();
        return {bus_if.en_reg_out_7_0, bus_if.en_reg_out_15_8, bus_if.en_reg_pwm_7_0,
                bus_if.en_reg_pwm_15_8, bus_if.pwm_duty_cycle};
    endfunction

    function automatic logic [39:0] model_regs();
        return {m_regs[0], m_regs[1], m_regs[2], m_regs[3], m_regs[4]};
    endfunction

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_frame(input logic [15:0] word, input int nbits);
        exp_t e;
        e.wr  = 1'b0;
        e.err = 1'b0;
        if (nbits != 16) begin
            e.err = 1'b1;
        end else if (word[15] && (word[14:8] <= 7'h04)) begin
            m_regs[word[14:8]] = word[7:0];
            e.wr = 1'b1;
        end
        e.regs = model_regs();
        sb_q.push_back(e);
    endtask

    task automatic spi_begin();
        bus_if.ncs = 1'b0;
        wait_clk(5);
    endtask

    task automatic spi_bits(input logic [15:0] word, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (i < 16) bus_if.copi = word[15-i];
            else        bus_if.copi = 1'b0;
            wait_clk(5);
            bus_if.sclk = 1'b1;
            wait_clk(5);
            bus_if.sclk = 1'b0;
        end
    endtask

    task automatic spi_end();
        wait_clk(5);
        bus_if.ncs = 1'b1;
    endtask

    // ncs was raised at a negedge; E0 is the next posedge. Result is due after E2, strobe gone after E3.
    task automatic check_commit(input string tag);
        exp_t e;
        e = '0;
        n_cmp++;
        assert (sb_q.size() > 0) else begin
            n_bad++;
            $error("FAIL %s_sb: observed empty queue expected an entry", tag);
        end
        if (sb_q.size() > 0) e = sb_q.pop_front();
        wait_clk(2);
        check({tag, "_early_pulse"}, {38'd0, bus_if.wr_strobe, bus_if.frame_err}, 40'd0);
        wait_clk(1);
        check({tag, "_wr"},   {39'd0, bus_if.wr_strobe}, {39'd0, e.wr});
        check({tag, "_err"},  {39'd0, bus_if.frame_err}, {39'd0, e.err});
        check({tag, "_regs"}, obs_regs(), e.regs);
        wait_clk(1);
        check({tag, "_pulse_end"}, {38'd0, bus_if.wr_strobe, bus_if.frame_err}, 40'd0);
        check({tag, "_hold"}, obs_regs(), e.regs);
        wait_clk(3);
    endtask

    task automatic send_frame(input string tag, input logic [15:0] word, input int nbits);
        expect_frame(word, nbits);
        spi_begin();
        spi_bits(word, 0, nbits);
        spi_end();
        check_commit(tag);
    endtask

    initial begin
        exp_t e;
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        rst = 1'b1;
        bus_if.sclk = 1'b0;
        bus_if.copi = 1'b0;
        bus_if.ncs  = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(1);
        check("reset_regs", obs_regs(), 40'd0);
        check("reset_pulses", {38'd0, bus_if.wr_strobe, bus_if.frame_err}, 40'd0);
        wait_clk(5);

        send_frame("w_addr0", 16'h80F0, 16);

        send_frame("b2b_0", 16'h80FF, 16);
        send_frame("b2b_1", 16'h81A5, 16);
        send_frame("b2b_2", 16'h823C, 16);
        send_frame("b2b_3", 16'h8301, 16);
        send_frame("b2b_4", 16'h8480, 16);

        send_frame("read_req", 16'h0055, 16);
        send_frame("bad_addr", 16'hB055, 16);

        send_frame("short12", 16'h8177, 12);
        send_frame("after_short", 16'h8177, 16);

        send_frame("long17", 16'h8233, 17);

        // Reset part-way through a frame: registers clear, rest of the frame is ignored.
        spi_begin();
        spi_bits(16'h8455, 0, 6);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        check("rst_duty", {32'd0, bus_if.pwm_duty_cycle}, 40'd0);
        check("rst_regs", obs_regs(), model_regs());
        e.wr   = 1'b0;
        e.err  = 1'b0;
        e.regs = model_regs();
        sb_q.push_back(e);
        spi_bits(16'h8455, 6, 16);
        spi_end();
        check_commit("rst_frame");

        send_frame("post_rst", 16'h8499, 16);
        send_frame("post_rst2", 16'h8266, 16);

        wait_clk(20);
        check("final_regs", obs_regs(), model_regs());
        check("final_sb_empty", 40'(sb_q.size()), 40'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
